// File: rtl/force_bank.sv
// force_bank: per-channel bus override unit.
//   Sits between normal bus drivers and their consumers. Any subset of channels
//   can be forced to a command-supplied value until released, or (with
//   FORCE_BANK_TIMED_EN defined) until a programmed cycle count expires.
//
// Configuration macro:
//   FORCE_BANK_TIMED_EN  defined     -> FORCE_TIMED counts down and auto-releases,
//                                       pulsing expired_o for one cycle.
//                        not defined -> no counters; FORCE_TIMED acts as FORCE,
//                                       cmd_dur ignored, expired_o tied 0.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   drv_i      normal driven values, channel i = [i*WIDTH +: WIDTH]
//   cmd_valid  command present
//   cmd_ready  command accepted on cmd_valid && cmd_ready (low during reset)
//   cmd_op     00 NOP, 01 FORCE, 10 RELEASE, 11 FORCE_TIMED
//   cmd_mask   channels targeted by the command
//   cmd_value  force values, same slicing as drv_i
//   cmd_dur    FORCE_TIMED duration in cycles (0 = permanent)
//   out_o      per channel: forced ? force value : drv_i slice
//   forced_o   per-channel forced flag (registered)
//   expired_o  one-cycle pulse when a timed force auto-releases (registered)

module force_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] drv_i,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [CHANNELS-1:0]       cmd_mask,
  input  logic [CHANNELS*WIDTH-1:0] cmd_value,
  input  logic [CNT_W-1:0]          cmd_dur,
  output logic [CHANNELS*WIDTH-1:0] out_o,
  output logic [CHANNELS-1:0]       forced_o,
  output logic [CHANNELS-1:0]       expired_o
);

  localparam logic [1:0] OP_NOP         = 2'b00;
  localparam logic [1:0] OP_RELEASE     = 2'b10;
  localparam logic [1:0] OP_FORCE_TIMED = 2'b11;

  logic [CHANNELS-1:0]       r_forced;
  logic [CHANNELS*WIDTH-1:0] r_fval;
  logic                      w_accept;

`ifdef FORCE_BANK_TIMED_EN
  logic [CHANNELS-1:0][CNT_W-1:0] r_cnt;
  logic [CHANNELS-1:0]            r_expired;
`else
  logic w_unused_dur;
  assign w_unused_dur = ^cmd_dur;
`endif

  // Ready simply tracks reset so nothing is accepted while the bank is held.
  assign cmd_ready = rst_n;
  assign w_accept  = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_forced <= '0;
      r_fval   <= '0;
`ifdef FORCE_BANK_TIMED_EN
      r_cnt     <= '0;
      r_expired <= '0;
`endif
    end else begin
`ifdef FORCE_BANK_TIMED_EN
      r_expired <= '0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        // A command hitting a channel takes priority over its countdown, so a
        // re-force on the expiry edge suppresses the expiry pulse.
        if (w_accept && cmd_mask[i] && (cmd_op != OP_NOP)) begin
          if (cmd_op == OP_RELEASE) begin
            r_forced[i] <= 1'b0;
`ifdef FORCE_BANK_TIMED_EN
            r_cnt[i] <= '0;
`endif
          end else begin
            r_forced[i]                  <= 1'b1;
            r_fval[i*WIDTH +: WIDTH]     <= cmd_value[i*WIDTH +: WIDTH];
`ifdef FORCE_BANK_TIMED_EN
            // cnt == 0 means permanent, which also covers FORCE_TIMED dur 0.
            r_cnt[i] <= (cmd_op == OP_FORCE_TIMED) ? cmd_dur : '0;
`endif
          end
        end
`ifdef FORCE_BANK_TIMED_EN
        else if (r_cnt[i] != '0) begin
          if (r_cnt[i] == CNT_W'(1)) begin
            r_forced[i]  <= 1'b0;
            r_cnt[i]     <= '0;
            r_expired[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          end
        end
`endif
      end
    end
  end

  always_comb begin
    out_o = drv_i;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_forced[i]) out_o[i*WIDTH +: WIDTH] = r_fval[i*WIDTH +: WIDTH];
    end
  end

  assign forced_o = r_forced;

`ifdef FORCE_BANK_TIMED_EN
  assign expired_o = r_expired;
`else
  assign expired_o = '0;
`endif

endmodule

// File: tb/tb_force_bank.sv
module tb_force_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] drv_i = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_mask = 2'b00;
  logic [7:0] cmd_value = 8'h00;
  logic [7:0] cmd_dur = 8'h00;
  logic [7:0] out_o;
  logic [1:0] forced_o;
  logic [1:0] expired_o;

  force_bank #(.WIDTH(4), .CHANNELS(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .drv_i(drv_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_mask(cmd_mask), .cmd_value(cmd_value), .cmd_dur(cmd_dur),
    .out_o(out_o), .forced_o(forced_o), .expired_o(expired_o)
  );

  always #5 clk = ~clk;

`ifdef FORCE_BANK_TIMED_EN
  localparam bit TIMED = 1'b1;
`else
  localparam bit TIMED = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a forced channel holds a value and, if timed, the
  // absolute edge number at which it lets go (0 = never).
  int         edge_no = 0;
  bit         m_forced [2];
  logic [3:0] m_fval   [2];
  int         m_release_at [2];
  logic [1:0] m_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_no, act, exp);
    end
  endtask

  task automatic model_edge();
    edge_no++;
    m_exp = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_forced[i] = 0; m_fval[i] = 4'h0; m_release_at[i] = 0;
      end else if (cmd_valid && cmd_mask[i] && cmd_op != 2'b00) begin
        if (cmd_op == 2'b10) begin
          m_forced[i] = 0; m_release_at[i] = 0;
        end else begin
          m_forced[i] = 1;
          m_fval[i]   = cmd_value[i*4 +: 4];
          m_release_at[i] = (TIMED && cmd_op == 2'b11 && cmd_dur != 0) ? edge_no + int'(cmd_dur) : 0;
        end
      end else if (m_forced[i] && m_release_at[i] != 0 && m_release_at[i] == edge_no) begin
        m_forced[i] = 0; m_release_at[i] = 0; m_exp[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    o = drv_i;
    for (int i = 0; i < 2; i++) if (m_forced[i]) o[i*4 +: 4] = m_fval[i];
    return o;
  endfunction

  // Apply one cycle of inputs, clock it, then compare DUT against the model.
  task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [1:0] m,
                      input logic [7:0] val, input logic [7:0] dur, input logic [7:0] drv);
    rst_n = r; cmd_valid = v; cmd_op = op; cmd_mask = m; cmd_value = val; cmd_dur = dur; drv_i = drv;
    #1;
    check("cmd_ready", 32'(cmd_ready), 32'(r));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmd_valid = 1'b0;
    check("out_o", 32'(out_o), 32'(model_out()));
    check("forced_o", 32'(forced_o), 32'({m_forced[1], m_forced[0]}));
    check("expired_o", 32'(expired_o), 32'(m_exp));
  endtask

  task automatic idle(input logic [7:0] drv);
    step(1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, drv);
  endtask

  typedef struct {
    logic       rst; logic vld; logic [1:0] op; logic [1:0] mask;
    logic [7:0] val; logic [7:0] dur; logic [7:0] drv;
    logic [7:0] e_out; logic [1:0] e_forced; logic [1:0] e_exp;
  } vec_t;

  vec_t vecs [10];
  logic [1:0] exp_seen;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h57, 8'h57, 2'b00, 2'b00};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 2'b11, 8'hFD, 8'h00, 8'h57, 8'hFD, 2'b11, 2'b00};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'hFD, 2'b11, 2'b00};
    vecs[3] = '{1'b1, 1'b1, 2'b10, 2'b01, 8'h00, 8'h00, 8'h00, 8'hF0, 2'b10, 2'b00};
    vecs[4] = '{1'b1, 1'b1, 2'b10, 2'b01, 8'h00, 8'h00, 8'h00, 8'hF0, 2'b10, 2'b00};
    vecs[5] = '{1'b1, 1'b1, 2'b10, 2'b10, 8'h00, 8'h00, 8'h5A, 8'h5A, 2'b00, 2'b00};
    vecs[6] = '{1'b1, 1'b1, 2'b01, 2'b10, 8'h3C, 8'h00, 8'h12, 8'h32, 2'b10, 2'b00};
    vecs[7] = '{1'b1, 1'b1, 2'b01, 2'b00, 8'hFF, 8'h00, 8'h12, 8'h32, 2'b10, 2'b00};
    vecs[8] = '{1'b1, 1'b0, 2'b01, 2'b11, 8'h00, 8'h00, 8'h45, 8'h35, 2'b10, 2'b00};
    vecs[9] = '{1'b1, 1'b1, 2'b10, 2'b11, 8'h00, 8'h00, 8'h45, 8'h45, 2'b00, 2'b00};

    for (int k = 0; k < 10; k++) begin
      step(vecs[k].rst, vecs[k].vld, vecs[k].op, vecs[k].mask, vecs[k].val, vecs[k].dur, vecs[k].drv);
      check($sformatf("vec%0d out", k), 32'(out_o), 32'(vecs[k].e_out));
      check($sformatf("vec%0d forced", k), 32'(forced_o), 32'(vecs[k].e_forced));
      check($sformatf("vec%0d expired", k), 32'(expired_o), 32'(vecs[k].e_exp));
    end

    // Timed force dur 3 on ch0: forced exactly 3 cycles, then one-cycle pulse.
    step(1'b1, 1'b1, 2'b11, 2'b01, 8'h02, 8'd3, 8'h57);
    check("timed c1", 32'(out_o), 32'h52);
    idle(8'h57); check("timed c2", 32'(out_o), 32'h52);
    idle(8'h57); check("timed c3", 32'(out_o), 32'h52);
    idle(8'h57);
    check("timed release out", 32'(out_o), TIMED ? 32'h57 : 32'h52);
    check("timed release pulse", 32'(expired_o), TIMED ? 32'h1 : 32'h0);
    idle(8'h57); check("timed pulse width", 32'(expired_o), 32'h0);

    // dur 0 is permanent.
    step(1'b1, 1'b1, 2'b11, 2'b01, 8'h0B, 8'd0, 8'h57);
    for (int k = 0; k < 8; k++) idle(8'h57);
    check("dur0 permanent", 32'(out_o), 32'h5B);
    step(1'b1, 1'b1, 2'b10, 2'b11, 8'h00, 8'h00, 8'h57);

    // Collision: FORCE accepted on the expiry edge wins, no pulse.
    exp_seen = 2'b00;
    step(1'b1, 1'b1, 2'b11, 2'b01, 8'h03, 8'd2, 8'h57);
    idle(8'h57);
    step(1'b1, 1'b1, 2'b01, 2'b01, 8'h09, 8'h00, 8'h57);
    exp_seen |= expired_o;
    check("collision out", 32'(out_o), 32'h59);
    for (int k = 0; k < 5; k++) begin idle(8'h57); exp_seen |= expired_o; end
    check("collision no pulse", 32'(exp_seen), 32'h0);
    check("collision permanent", 32'(forced_o), 32'h1);
    step(1'b1, 1'b1, 2'b10, 2'b11, 8'h00, 8'h00, 8'h57);

    // Reset in the middle of a timed force cancels it without a pulse.
    step(1'b1, 1'b1, 2'b11, 2'b10, 8'hA0, 8'd5, 8'h57);
    idle(8'h57); idle(8'h57);
    step(1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h57);
    check("reset ready", 32'(cmd_ready), 32'h0);
    check("reset forced", 32'(forced_o), 32'h0);
    check("reset out", 32'(out_o), 32'h57);
    exp_seen = 2'b00;
    for (int k = 0; k < 6; k++) begin idle(8'h57); exp_seen |= expired_o; end
    check("reset no pulse", 32'(exp_seen), 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [1:0] op, m;
      logic [7:0] dur;
      op  = 2'($urandom_range(0, 3));
      m   = 2'($urandom_range(0, 3));
      if (op == 2'b00) m = 2'b00;
      dur = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0), op, m,
           8'($urandom), dur, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
